mem_access_ctrl: RTL and testbench

Multi-cycle load/store sequencer between the MEM stage of the MIPS pipeline and the data-memory port. Accepts one decoded memory operation (LW/LH/LHU/LB/LBU/SW/SH/SB), drives a req/ack data-memory handshake with byte strobes, then sign/zero-extends the returned data for writeback. Holds `stall` to freeze the pipeline while a transaction is outstanding.

---
 rtl/mem_access_ctrl_if.sv | 21 ++
 rtl/mem_access_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: data-memory request/acknowledge bus between the
// load/store sequencer (master) and the data-memory port (slave).
interface mem_access_ctrl_if;
    logic        req;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, we, wstrb, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, wstrb, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multi-cycle load/store sequencer between the MIPS MEM
// stage and the data-memory port. Drives a req/ack handshake with byte
// strobes, extends returned load data and holds stall while busy.
// Optional feature: define MEM_MISALIGN_EXC_EN to raise adel/ades on
// misaligned word/half accesses instead of silently aligning them.
module mem_access_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata_in,
    input  logic              flush,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata_out,
    output logic              adel,
    output logic              ades,
    output logic              bus_err,
    mem_access_ctrl_if.master dm
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [7:0]  cnt;
    logic        kill;
    logic        err_adel;
    logic        err_ades;
    logic        err_bus;

    // Transaction operands: no reset, every output use is gated by state.
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic        misalign;
    logic [31:0] addr_eff;

    function automatic logic is_store(input logic [2:0] o);
        return o >= OP_SW;
    endfunction

    function automatic logic misaligned(input logic [2:0] o, input logic [31:0] a);
        case (o)
            OP_LW, OP_SW:          return a[1:0] != 2'b00;
            OP_LH, OP_LHU, OP_SH:  return a[0];
            default:               return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] force_align(input logic [2:0] o, input logic [31:0] a);
        case (o)
            OP_LW, OP_SW:          return {a[31:2], 2'b00};
            OP_LH, OP_LHU, OP_SH:  return {a[31:1], 1'b0};
            default:               return a;
        endcase
    endfunction

    function automatic logic [3:0] strobe(input logic [2:0] o, input logic [1:0] a2);
        case (o)
            OP_SW:   return 4'b1111;
            OP_SH:   return a2[1] ? 4'b1100 : 4'b0011;
            OP_SB:   return 4'b0001 << a2;
            default: return 4'b0000;
        endcase
    endfunction

    // Stores replicate the source across all lanes; strobes pick the lane.
    function automatic logic [31:0] store_data(input logic [2:0] o, input logic [31:0] w);
        case (o)
            OP_SW:   return w;
            OP_SH:   return {2{w[15:0]}};
            OP_SB:   return {4{w[7:0]}};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] o, input logic [1:0] a2,
                                                input logic [31:0] d);
        logic        [7:0]  b;
        logic        [15:0] h;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        b  = d[{a2, 3'b000} +: 8];
        h  = a2[1] ? d[31:16] : d[15:0];
        sb = b;
        sh = h;
        case (o)
            OP_LW:   return d;
            OP_LH:   return 32'(sh);
            OP_LHU:  return {16'd0, h};
            OP_LB:   return 32'(sb);
            OP_LBU:  return {24'd0, b};
            default: return 32'd0;
        endcase
    endfunction

`ifdef MEM_MISALIGN_EXC_EN
    assign misalign = misaligned(op, addr);
    assign addr_eff = addr;
`else
    assign misalign = 1'b0;
    assign addr_eff = force_align(op, addr);
`endif

    assign accept = (state == S_IDLE) && start && !flush;

    // Control FSM: sequencing, timeout counter, kill and error flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            cnt      <= 8'd0;
            kill     <= 1'b0;
            err_adel <= 1'b0;
            err_ades <= 1'b0;
            err_bus  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt     <= 8'd0;
                        kill    <= 1'b0;
                        err_bus <= 1'b0;
                        if (misalign) begin
                            state    <= S_FIN;
                            err_adel <= !is_store(op);
                            err_ades <= is_store(op);
                        end else begin
                            state    <= S_REQ;
                            err_adel <= 1'b0;
                            err_ades <= 1'b0;
                        end
                    end
                end
                S_REQ: begin
                    // A flush cannot retract an issued request; it only
                    // suppresses the completion reported to the pipeline.
                    if (flush) kill <= 1'b1;
                    if (dm.ack) begin
                        state <= S_FIN;
                    end else if (cnt == CNT_LAST) begin
                        state   <= S_FIN;
                        err_bus <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_FIN: begin
                    state    <= S_IDLE;
                    cnt      <= 8'd0;
                    kill     <= 1'b0;
                    err_adel <= 1'b0;
                    err_ades <= 1'b0;
                    err_bus  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Operand capture on accept; extended load data latched on ack.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= op;
            addr_q  <= addr_eff;
            wdata_q <= wdata_in;
            rdata_q <= 32'd0;
        end else if ((state == S_REQ) && dm.ack) begin
            rdata_q <= is_store(op_q) ? 32'd0 : load_extend(op_q, addr_q[1:0], dm.rdata);
        end
    end

    // Output decode: bus fields only while requesting, results only on done.
    always_comb begin
        stall     = accept || (state == S_REQ);
        done      = (state == S_FIN) && !kill;
        adel      = done && err_adel;
        ades      = done && err_ades;
        bus_err   = done && err_bus;
        rdata_out = done ? rdata_q : 32'd0;
        dm.req    = (state == S_REQ);
        dm.we     = 1'b0;
        dm.wstrb  = 4'b0000;
        dm.addr   = 32'd0;
        dm.wdata  = 32'd0;
        if (state == S_REQ) begin
            dm.we    = is_store(op_q);
            dm.wstrb = strobe(op_q, addr_q[1:0]);
            dm.addr  = {addr_q[31:2], 2'b00};
            dm.wdata = store_data(op_q, wdata_q);
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl. Stimulus pushes
// expected bus requests and completions; a negedge monitor pops and checks.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
    localparam int TMO = 8;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata_in = 32'd0;
    logic        stall, done, adel, ades, bus_err;
    logic [31:0] rdata_out;

    mem_access_ctrl_if dmi();

    mem_access_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .addr(addr),
        .wdata_in(wdata_in), .flush(flush), .stall(stall), .done(done),
        .rdata_out(rdata_out), .adel(adel), .ades(ades), .bus_err(bus_err),
        .dm(dmi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] rdata;
        logic        adel;
        logic        ades;
        logic        berr;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } bus_t;

    exp_t exp_q[$];
    bus_t bus_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: byte-lane arithmetic straight from the load/store rules.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                                  input logic [31:0] rd, input bit tmo, output bit mis,
                                  output exp_t e, output bus_t b);
        int          sz;
        int          lane;
        bit          st;
        logic [31:0] ea;
        longint      raw;
        st = (o >= OP_SW);
        sz = (o == OP_LW || o == OP_SW) ? 4 : (o == OP_LH || o == OP_LHU || o == OP_SH) ? 2 : 1;
`ifdef MEM_MISALIGN_EXC_EN
        mis = (a % sz) != 0;
        ea  = a;
`else
        mis = 1'b0;
        ea  = a - (a % sz);
`endif
        lane = int'(ea % 4);
        e.adel = mis && !st;
        e.ades = mis && st;
        e.berr = !mis && tmo;
        e.cyc  = 0;
        if (st || mis || tmo) begin
            e.rdata = 32'd0;
        end else begin
            raw = longint'(rd >> (8 * lane));
            if (sz < 4) raw = raw % (64'sd1 << (8 * sz));
            if ((o == OP_LB || o == OP_LH) && raw >= (64'sd1 << (8 * sz - 1)))
                raw = raw - (64'sd1 << (8 * sz));
            e.rdata = raw[31:0];
        end
        b.addr  = ea - (ea % 4);
        b.we    = st;
        b.strb  = st ? 4'(((1 << sz) - 1) << lane) : 4'b0000;
        b.wdata = (sz == 4) ? w : (sz == 2) ? (w % 65536) * 32'h0001_0001
                                            : (w % 256) * 32'h0101_0101;
    endfunction

    // Monitor: checks bus requests and completions against the scoreboard.
    logic req_prev = 1'b0;
    bus_t held;
    bus_t mon_b;
    exp_t mon_e;
    always @(negedge clk) begin
        if (!resetn) begin
            req_prev = 1'b0;
        end else begin
            if (dmi.req && !req_prev) begin
                if (bus_q.size() == 0) begin
                    chk("unexpected_req", 32'd1, 32'd0);
                end else begin
                    mon_b = bus_q.pop_front();
                    chk("dm_addr", dmi.addr, mon_b.addr);
                    chk("dm_we", {31'd0, dmi.we}, {31'd0, mon_b.we});
                    chk("dm_wstrb", {28'd0, dmi.wstrb}, {28'd0, mon_b.strb});
                    if (mon_b.we) chk("dm_wdata", dmi.wdata, mon_b.wdata);
                end
                held = '{dmi.addr, dmi.we, dmi.wstrb, dmi.wdata};
            end else if (dmi.req) begin
                chk("req_stable_addr", dmi.addr, held.addr);
                chk("req_stable_ctl", {dmi.wdata[26:0], dmi.we, dmi.wstrb},
                                      {held.wdata[26:0], held.we, held.strb});
            end
            req_prev = dmi.req;
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rdata_out", rdata_out, mon_e.rdata);
                    chk("err_flags", {29'd0, adel, ades, bus_err},
                                     {29'd0, mon_e.adel, mon_e.ades, mon_e.berr});
                    chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
                end
            end else begin
                chk("quiet_outputs", {28'd0, adel, ades, bus_err, |rdata_out}, 32'd0);
            end
        end
    end

    // One transaction; returns #1 into the FIN cycle.
    task automatic run_txn(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                           input logic [31:0] rd, input int lat, input int flush_k, input bit noack);
        bit   mis;
        exp_t e;
        bus_t b;
        int   c0;
        bit   killed;
        model(o, a, w, rd, noack, mis, e, b);
        killed = (flush_k >= 0) && !mis;
        @(negedge clk);
        start = 1'b1; op = o; addr = a; wdata_in = w; flush = 1'b0;
        c0 = cyc;
        e.cyc = mis ? c0 + 1 : noack ? c0 + 1 + TMO : c0 + 2 + lat;
        if (!mis) bus_q.push_back(b);
        if (!killed) exp_q.push_back(e);
        #1 chk("stall_accept", {31'd0, stall}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        if (!mis) begin
            for (int k = 0; k < TMO; k++) begin
                flush = (k == flush_k);
                dmi.ack = !noack && (k == lat);
                dmi.rdata = dmi.ack ? rd : $urandom;
                #1 chk("stall_req", {31'd0, stall}, 32'd1);
                @(negedge clk);
                dmi.ack = 1'b0;
                flush = 1'b0;
                if (!noack && k == lat) break;
            end
        end
        #1 chk("stall_fin", {31'd0, stall}, 32'd0);
    endtask

    initial begin
        dmi.ack = 1'b0;
        dmi.rdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {26'd0, stall, done, adel, ades, bus_err, dmi.req}, 32'd0);
        chk("reset_rdata", rdata_out, 32'd0);
        chk("reset_bus", dmi.addr | dmi.wdata | {28'd0, dmi.wstrb} | {31'd0, dmi.we}, 32'd0);
        resetn = 1'b1;

        // Byte loads, zero-wait memory.
        run_txn(OP_LB,  32'h103, 32'h0, 32'h80FF_1234, 0, -1, 1'b0);
        run_txn(OP_LBU, 32'h103, 32'h0, 32'h80FF_1234, 0, -1, 1'b0);
        // Halfword store with three wait cycles.
        run_txn(OP_SH,  32'h202, 32'h1234_ABCD, 32'h0, 3, -1, 1'b0);
        // Misaligned word load.
        run_txn(OP_LW,  32'h301, 32'h0, 32'hDEAD_BEEF, 0, -1, 1'b0);
        // Flush two cycles into REQ, ack later.
        run_txn(OP_LW,  32'h340, 32'h0, 32'h1111_2222, 4, 2, 1'b0);
        // Timeout, then a late ack while idle.
        run_txn(OP_LH,  32'h402, 32'h0, 32'h0, 0, -1, 1'b1);
        chk("req_dropped_fin", {31'd0, dmi.req}, 32'd0);
        @(negedge clk);
        dmi.ack = 1'b1; dmi.rdata = 32'hCAFE_F00D;
        repeat (2) @(negedge clk);
        dmi.ack = 1'b0;

        // start presented during FIN is ignored.
        run_txn(OP_SB, 32'h503, 32'h0000_00A5, 32'h0, 1, -1, 1'b0);
        start = 1'b1; op = OP_SW; addr = 32'h600; wdata_in = 32'h1;
        #1 chk("stall_start_in_fin", {31'd0, stall}, 32'd0);
        @(negedge clk);
        start = 1'b0;

        // start together with flush is ignored.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = OP_LW; addr = 32'h700;
        #1 chk("stall_start_flush", {31'd0, stall}, 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a request.
        start = 1'b1; op = OP_LW; addr = 32'h800;
        bus_q.push_back('{32'h800, 1'b0, 4'b0000, 32'h0});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 resetn = 1'b0;
        #1 chk("async_reset_outputs", {26'd0, stall, done, adel, ades, bus_err, dmi.req}, 32'd0);
        chk("async_reset_bus", dmi.addr, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        run_txn(OP_LW, 32'h900, 32'h0, 32'h7654_3210, 1, -1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            logic [2:0] o;
            int         lat, r, fk;
            bit         na;
            o   = 3'($urandom_range(0, 7));
            lat = $urandom_range(0, 3);
            r   = $urandom_range(0, 9);
            na  = (r == 0);
            fk  = (r == 1 || r == 2) ? $urandom_range(0, na ? TMO - 1 : lat) : -1;
            run_txn(o, $urandom, $urandom, $urandom, lat, fk, na);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("pending_done", 32'(exp_q.size()), 32'd0);
        chk("pending_req", 32'(bus_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
